// File: rtl/calc_pkg.sv
// Shared types and helpers for the calculator sequencer: FSM state encoding,
// datapath widths and the sign-extension / truncation-detect helpers.
package calc_pkg;

    localparam int DATA_W   = 16;
    localparam int EXT_W    = 32;
    localparam int OP_SEL_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_e;

    function automatic logic [EXT_W-1:0] sext(input logic [DATA_W-1:0] v);
        return {{(EXT_W-DATA_W){v[DATA_W-1]}}, v};
    endfunction

    // True when the 32-bit result does not survive truncation to 16 signed bits.
    function automatic logic is_trunc(input logic [EXT_W-1:0] r);
        return r[EXT_W-1:DATA_W] != {(EXT_W-DATA_W){r[DATA_W-1]}};
    endfunction

endpackage

// File: rtl/calc_ctrl_btn_debounce.sv
// Push-button conditioner: two-flop synchronizer, stability counter and a
// one-cycle rising-edge pulse on the debounced level.
module btn_debounce
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic resetn,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flip;

    // The level flips only on the DEBOUNCE_CYCLES-th consecutive differing sample.
    assign flip = (sync2_q != level_q) && (cnt_q == '0);

    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        if (sync2_q == level_q) begin
            cnt_d = RELOAD;
        end else if (flip) begin
            level_d = sync2_q;
            cnt_d   = RELOAD;
            rise_d  = sync2_q;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= RELOAD;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/calc_ctrl.sv
// Calculator sequencer: conditions the five buttons, latches operand/operation on
// execute and walks the external ALU through IDLE -> EXEC -> WB into the accumulator.
module calc_ctrl
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int ALU_LAT         = 1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [DATA_W-1:0]   sw,
    input  logic                btnc,
    input  logic                btnl,
    input  logic                btnr,
    input  logic                btnu,
    input  logic                btnd,
    output logic [OP_SEL_W-1:0] op_sel,
    output logic [EXT_W-1:0]    op1,
    output logic [EXT_W-1:0]    op2,
    input  logic [EXT_W-1:0]    alu_result,
    input  logic                alu_zero,
    output logic [DATA_W-1:0]   led,
    output logic                busy,
    output logic                done,
    output logic                zero,
    output logic                trunc,
    output logic                ovr
);

    localparam int LAT_W = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);
    localparam logic [LAT_W-1:0] LAT_RELOAD = LAT_W'(ALU_LAT - 1);

    // Button order: {btnu, btnd, btnl, btnc, btnr}
    logic [4:0] btn_raw, btn_lvl, btn_rise;
    logic       exec_pulse, clr_pulse;
    logic       unused_btn;

    assign btn_raw = {btnu, btnd, btnl, btnc, btnr};

    for (genvar g = 0; g < 5; g++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk    (clk),
            .resetn (resetn),
            .btn_i  (btn_raw[g]),
            .level_o(btn_lvl[g]),
            .rise_o (btn_rise[g])
        );
    end

    assign clr_pulse  = btn_rise[4];
    assign exec_pulse = btn_rise[3];
    assign unused_btn = ^{btn_lvl[4:3], btn_rise[2:0]};

    state_e state_q, state_d;

    logic                busy_c, accept_c, wb_en_c, overrun_c;
    logic [LAT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]   sw_q, sw_d;
    logic [OP_SEL_W-1:0] op_sel_q, op_sel_d;
    logic                zero_q, zero_d;
    logic                trunc_q, trunc_d;
    logic                ovr_q, ovr_d;
    logic                done_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Clear outranks everything, including a same-cycle execute press.
    always_comb begin
        state_d = state_q;
        if (clr_pulse) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (exec_pulse) state_d = ST_EXEC;
                ST_EXEC: if (cnt_q == '0) state_d = ST_WB;
                ST_WB:   state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy_c    = (state_q != ST_IDLE);
        accept_c  = (state_q == ST_IDLE) && exec_pulse && !clr_pulse;
        wb_en_c   = (state_q == ST_WB) && !clr_pulse;
        overrun_c = busy_c && exec_pulse && !clr_pulse;
    end

    always_comb begin
        cnt_d    = cnt_q;
        sw_d     = sw_q;
        op_sel_d = op_sel_q;
        acc_d    = acc_q;
        zero_d   = zero_q;
        trunc_d  = trunc_q;
        ovr_d    = ovr_q;
        if (accept_c) begin
            sw_d     = sw;
            op_sel_d = {btn_lvl[2], btn_lvl[1], btn_lvl[0]};
            cnt_d    = LAT_RELOAD;
        end else if ((state_q == ST_EXEC) && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
        if (clr_pulse) begin
            acc_d   = '0;
            zero_d  = 1'b0;
            trunc_d = 1'b0;
            ovr_d   = 1'b0;
        end else begin
            if (wb_en_c) begin
                acc_d   = alu_result[DATA_W-1:0];
                zero_d  = alu_zero;
                trunc_d = is_trunc(alu_result);
            end
            if (overrun_c) ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q    <= '0;
            sw_q     <= '0;
            op_sel_q <= '0;
            acc_q    <= '0;
            zero_q   <= 1'b0;
            trunc_q  <= 1'b0;
            ovr_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sw_q     <= sw_d;
            op_sel_q <= op_sel_d;
            acc_q    <= acc_d;
            zero_q   <= zero_d;
            trunc_q  <= trunc_d;
            ovr_q    <= ovr_d;
            done_q   <= wb_en_c;
        end
    end

    assign op_sel = op_sel_q;
    assign op1    = sext(acc_q);
    assign op2    = sext(sw_q);
    assign led    = acc_q;
    assign busy   = busy_c;
    assign done   = done_q;
    assign zero   = zero_q;
    assign trunc  = trunc_q;
    assign ovr    = ovr_q;

endmodule

// File: tb/tb_calc_ctrl.sv
// Directed + randomized bench for calc_ctrl with a behavioural adder ALU and a
// reference accumulator model; a second instance with ALU_LAT=8 covers overrun/abort.
module tb_calc_ctrl;

    localparam int D    = 4;
    localparam int LAT  = 1;
    localparam int LAT8 = 8;
    // raw press -> 2 sync flops -> D stable samples -> pulse -> state register
    localparam int BUSY_AT = 2 + D + 1;

    logic        clk;
    logic        resetn, resetn8;
    logic [15:0] sw, sw8;
    logic        btnc, btnl, btnr, btnu, btnd;
    logic        btnc8, btnl8, btnr8, btnu8, btnd8;
    logic [2:0]  op_sel, op_sel8;
    logic [31:0] op1, op2, op1_8, op2_8;
    logic [31:0] alu_result, alu_result8;
    logic        alu_zero, alu_zero8;
    logic [15:0] led, led8;
    logic        busy, done, zero, trunc, ovr;
    logic        busy8, done8, zero8, trunc8, ovr8;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int fail_cnt = 0;

    logic [15:0] acc_m;
    logic        trunc_m, zero_m, ovr_m;
    logic [2:0]  opsel_m;

    assign alu_result  = op1 + op2;
    assign alu_zero    = (alu_result == 32'd0);
    assign alu_result8 = op1_8 + op2_8;
    assign alu_zero8   = (alu_result8 == 32'd0);

    calc_ctrl #(.DEBOUNCE_CYCLES(D), .ALU_LAT(LAT)) dut (
        .clk(clk), .resetn(resetn), .sw(sw),
        .btnc(btnc), .btnl(btnl), .btnr(btnr), .btnu(btnu), .btnd(btnd),
        .op_sel(op_sel), .op1(op1), .op2(op2),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .led(led), .busy(busy), .done(done), .zero(zero), .trunc(trunc), .ovr(ovr)
    );

    calc_ctrl #(.DEBOUNCE_CYCLES(D), .ALU_LAT(LAT8)) dut8 (
        .clk(clk), .resetn(resetn8), .sw(sw8),
        .btnc(btnc8), .btnl(btnl8), .btnr(btnr8), .btnu(btnu8), .btnd(btnd8),
        .op_sel(op_sel8), .op1(op1_8), .op2(op2_8),
        .alu_result(alu_result8), .alu_zero(alu_zero8),
        .led(led8), .busy(busy8), .done(done8), .zero(zero8), .trunc(trunc8), .ovr(ovr8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sx(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    // Reference: accumulator += operand in plain integer arithmetic.
    task automatic model_exec(input logic [15:0] s, input logic [2:0] osel);
        int sum;
        sum     = int'($signed(acc_m)) + int'($signed(s));
        trunc_m = (sum > 32767) || (sum < -32768);
        zero_m  = (sum == 0);
        acc_m   = sum[15:0];
        opsel_m = osel;
    endtask

    task automatic exec_op(input string tag, input logic [15:0] s, input int hold);
        int          busy_at, done_at, dones;
        logic [31:0] op1_seen, op2_seen, op1_exp;
        logic [2:0]  opsel_seen;
        busy_at = 0; done_at = 0; dones = 0;
        op1_seen = '0; op2_seen = '0; opsel_seen = '0;
        op1_exp = sx(acc_m);
        sw   = s;
        btnd = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == hold) btnd = 1'b0;
            if (busy && busy_at == 0) begin
                busy_at    = i;
                op1_seen   = op1;
                op2_seen   = op2;
                opsel_seen = op_sel;
            end
            if (done) begin
                dones++;
                if (done_at == 0) done_at = i;
            end
        end
        model_exec(s, {btnl, btnc, btnr});
        check({tag, "_busy_lat"}, busy_at, BUSY_AT);
        check({tag, "_done_lat"}, done_at, BUSY_AT + LAT + 1);
        check({tag, "_done_cnt"}, dones, 1);
        check({tag, "_op1"}, op1_seen, op1_exp);
        check({tag, "_op2"}, op2_seen, sx(s));
        check({tag, "_opsel"}, {29'd0, opsel_seen}, {29'd0, opsel_m});
        check({tag, "_led"}, {16'd0, led}, {16'd0, acc_m});
        check({tag, "_trunc"}, {31'd0, trunc}, {31'd0, trunc_m});
        check({tag, "_zero"}, {31'd0, zero}, {31'd0, zero_m});
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
        check({tag, "_ovr"}, {31'd0, ovr}, {31'd0, ovr_m});
    endtask

    initial begin
        int          seen_busy, dones8;
        logic [15:0] rs;
        logic [2:0]  rop;

        resetn = 1'b0; resetn8 = 1'b0;
        sw = '0; sw8 = '0;
        {btnc, btnl, btnr, btnu, btnd} = '0;
        {btnc8, btnl8, btnr8, btnu8, btnd8} = '0;
        acc_m = '0; trunc_m = 1'b0; zero_m = 1'b0; ovr_m = 1'b0; opsel_m = '0;

        // Reset state
        ticks(3);
        check("rst_led", {16'd0, led}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ovr", {31'd0, ovr}, 32'd0);
        check("rst_opsel", {29'd0, op_sel}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        resetn = 1'b1; resetn8 = 1'b1;
        ticks(3);

        // Basic execute
        exec_op("basic5", 16'h0005, 6);
        check("basic5_val", {16'd0, led}, 32'h0005);
        exec_op("basicm3", 16'hFFFD, 6);
        check("basicm3_val", {16'd0, led}, 32'h0002);

        // Glitches shorter than the debounce window
        btnd = 1'b1; ticks(2); btnd = 1'b0;
        seen_busy = 0;
        for (int i = 0; i < 20; i++) begin tick(); if (busy || done) seen_busy++; end
        check("glitch_d_busy", seen_busy, 0);
        check("glitch_d_led", {16'd0, led}, {16'd0, acc_m});
        btnu = 1'b1; ticks(3); btnu = 1'b0;
        ticks(20);
        check("glitch_u_led", {16'd0, led}, {16'd0, acc_m});

        // Simultaneous clear and execute: clear wins
        sw = 16'h1234;
        btnu = 1'b1; btnd = 1'b1; ticks(6); btnu = 1'b0; btnd = 1'b0;
        seen_busy = 0;
        for (int i = 0; i < 20; i++) begin tick(); if (busy || done) seen_busy++; end
        acc_m = '0; trunc_m = 1'b0; zero_m = 1'b0; ovr_m = 1'b0;
        check("both_busy", seen_busy, 0);
        check("both_led", {16'd0, led}, 32'd0);
        check("both_ovr", {31'd0, ovr}, 32'd0);

        // Truncation boundary then clear
        exec_op("max", 16'h7FFF, 6);
        exec_op("wrap", 16'h0001, 6);
        check("wrap_val", {16'd0, led}, 32'h8000);
        check("wrap_trunc", {31'd0, trunc}, 32'd1);
        btnu = 1'b1; ticks(6); btnu = 1'b0; ticks(20);
        acc_m = '0; trunc_m = 1'b0; zero_m = 1'b0;
        check("clr_led", {16'd0, led}, 32'd0);
        check("clr_trunc", {31'd0, trunc}, 32'd0);
        check("clr_zero", {31'd0, zero}, 32'd0);

        // Randomized operands and operation selects
        for (int k = 0; k < 8; k++) begin
            rop = 3'($urandom_range(0, 7));
            {btnl, btnc, btnr} = rop;
            ticks(10);
            rs = 16'($urandom);
            if (k == 3) rs = 16'(-int'($signed(acc_m)));
            if (k == 5) rs = 16'h8000;
            exec_op("rand", rs, 6);
        end
        {btnl, btnc, btnr} = 3'b000;
        ticks(10);

        // Overrun on the long-latency instance: second press lands in EXEC
        sw8 = 16'h0003;
        dones8 = 0;
        btnd8 = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 4)  btnd8 = 1'b0;
            if (i == 8)  btnd8 = 1'b1;
            if (i == 12) btnd8 = 1'b0;
            if (done8) dones8++;
        end
        check("ovr_flag", {31'd0, ovr8}, 32'd1);
        check("ovr_led", {16'd0, led8}, 32'h0003);
        check("ovr_dones", dones8, 1);
        check("ovr_idle", {31'd0, busy8}, 32'd0);

        // Clear during EXEC aborts the operation
        sw8 = 16'h0009;
        dones8 = 0;
        btnd8 = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 4) btnd8 = 1'b0;
            if (i == BUSY_AT) begin
                check("abu_busy", {31'd0, busy8}, 32'd1);
                btnu8 = 1'b1;
            end
            if (i == BUSY_AT + 4) btnu8 = 1'b0;
            if (done8) dones8++;
        end
        check("abu_led", {16'd0, led8}, 32'd0);
        check("abu_dones", dones8, 0);
        check("abu_busy_end", {31'd0, busy8}, 32'd0);
        check("abu_ovr", {31'd0, ovr8}, 32'd0);

        // Normal long-latency op, then reset mid-EXEC
        sw8 = 16'h0011;
        dones8 = 0;
        seen_busy = 0;
        btnd8 = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 4) btnd8 = 1'b0;
            if (busy8 && seen_busy == 0) seen_busy = i;
            if (done8) begin
                dones8++;
                check("lat8_done", i, BUSY_AT + LAT8 + 1);
            end
        end
        check("lat8_busy", seen_busy, BUSY_AT);
        check("lat8_led", {16'd0, led8}, 32'h0011);
        check("lat8_dones", dones8, 1);

        sw8 = 16'h0022;
        dones8 = 0;
        btnd8 = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 4) btnd8 = 1'b0;
            if (i == BUSY_AT + 2) begin
                check("arst_busy_pre", {31'd0, busy8}, 32'd1);
                resetn8 = 1'b0;
                #1;
                check("arst_led", {16'd0, led8}, 32'd0);
                check("arst_busy", {31'd0, busy8}, 32'd0);
            end
            if (i == BUSY_AT + 5) resetn8 = 1'b1;
            if (done8) dones8++;
        end
        check("arst_dones", dones8, 0);
        check("arst_led_end", {16'd0, led8}, 32'd0);
        check("arst_busy_end", {31'd0, busy8}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
